// File: rtl/filter_arb_pkg.sv
// Shared types and sizing helpers for the filter arbiter and its filter stage.
package filter_arb_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_NUM_REQ = 4;

  // Requester-index width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_W = id_w(DEF_NUM_REQ);

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  parity;
    logic [DEF_ID_W-1:0]   id;
  } filter_word_t;

endpackage

// File: rtl/filter_arbiter_stage.sv
// Single registered filter stage: shift left by one, insert parity at LSB,
// shifted-out MSB becomes the new parity; id and valid travel alongside.
module filter_stage
  import filter_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x_valid_i,
  input  logic [DATA_W-1:0] x_data_i,
  input  logic              x_parity_i,
  input  logic [ID_W-1:0]   x_id_i,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  output logic              y_parity_o,
  output logic [ID_W-1:0]   y_id_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              parity_q;
  logic [ID_W-1:0]   id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      parity_q <= 1'b0;
      id_q     <= '0;
    end else begin
      valid_q <= x_valid_i;
      if (x_valid_i) begin
        data_q   <= {x_data_i[DATA_W-2:0], x_parity_i};
        parity_q <= x_data_i[DATA_W-1];
        id_q     <= x_id_i;
      end
    end
  end

  assign y_valid_o  = valid_q;
  assign y_data_o   = data_q;
  assign y_parity_o = parity_q;
  assign y_id_o     = id_q;

endmodule

// File: rtl/filter_arbiter.sv
// Round-robin arbiter sharing one filter stage, with a credit-checked output FIFO.
// Optional grant/stall counters are built when FILTER_ARB_STATS_EN is defined.
module filter_arbiter
  import filter_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 2,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] io_req_data,
  input  logic [NUM_REQ-1:0]        io_req_parity,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  output logic [NUM_REQ-1:0]        io_req_ready,
  output logic [DATA_W-1:0]         io_resp_data,
  output logic                      io_resp_parity,
  output logic [ID_W-1:0]           io_resp_id,
  output logic                      io_resp_valid,
  input  logic                      io_resp_ready
`ifdef FILTER_ARB_STATS_EN
  ,
  output logic [31:0]               io_stat_grants,
  output logic [31:0]               io_stat_stalls
`endif
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = DATA_W + 1 + ID_W;

  logic [DATA_W-1:0]  req_word [NUM_REQ];
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    gnt_idx, cand;
  logic               gnt_found, issue_ok, accept, pop;
  logic               stage_valid, stage_parity;
  logic [DATA_W-1:0]  stage_data;
  logic [ID_W-1:0]    stage_id;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_word
      assign req_word[gi] = io_req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign pop           = io_resp_valid & io_resp_ready;
  assign io_resp_valid = (count_q != '0);
  // Results already committed (FIFO + stage) minus this cycle's pop must leave a free slot.
  assign issue_ok      = (int'(count_q) + int'(stage_valid) - int'(pop)) < DEPTH;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_found && io_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    io_req_ready = '0;
    if (gnt_found && issue_ok && !reset) io_req_ready[gnt_idx] = 1'b1;
  end

  assign accept   = |(io_req_valid & io_req_ready);
  assign rr_ptr_d = accept ? gnt_idx : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= ID_W'(NUM_REQ - 1);
    else       rr_ptr_q <= rr_ptr_d;
  end

  filter_stage #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_stage (
    .clk        (clk),
    .reset      (reset),
    .x_valid_i  (accept),
    .x_data_i   (req_word[gnt_idx]),
    .x_parity_i (io_req_parity[gnt_idx]),
    .x_id_i     (gnt_idx),
    .y_valid_o  (stage_valid),
    .y_data_o   (stage_data),
    .y_parity_o (stage_parity),
    .y_id_o     (stage_id)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    if (stage_valid && !pop)      count_d = count_q + CNT_W'(1);
    else if (!stage_valid && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      if (stage_valid) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)         rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (stage_valid) mem_q[wr_ptr_q] <= {stage_data, stage_parity, stage_id};
  end

  assign {io_resp_data, io_resp_parity, io_resp_id} = mem_q[rd_ptr_q];

  assert property (@(posedge clk) disable iff (reset) int'(count_q) <= DEPTH);

`ifdef FILTER_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_stalls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (accept && stat_grants_q != '1)
        stat_grants_q <= stat_grants_q + 32'd1;
      if ((|io_req_valid) && !issue_ok && stat_stalls_q != '1)
        stat_stalls_q <= stat_stalls_q + 32'd1;
    end
  end

  assign io_stat_grants = stat_grants_q;
  assign io_stat_stalls = stat_stalls_q;
`endif

endmodule
